// File: rtl/sram_scan_driver.sv
// rtl/sram_scan_driver.sv - parallel command to SRAM scan-wrapper serial driver with read capture
// Optional rdata_par output (even parity of captured word) when SCAN_PARITY_EN is defined.
module sram_scan_driver #(
    parameter int N_addr  = 32,
    parameter int N_cnt   = 31,
    parameter int N_data  = 32,
    parameter int RST_CYC = 4,
    parameter int CAP_DLY = 64
) (
    input  logic              scan_clk,
    input  logic              scan_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N_addr-1:0] cmd_addr,
    input  logic [N_cnt-2:0]  cmd_cnt,
    input  logic              cmd_we,
    input  logic [N_data-1:0] cmd_wdata,
    output logic              rdata_valid,
    output logic [N_data-1:0] rdata,
`ifdef SCAN_PARITY_EN
    output logic              rdata_par,
`endif
    output logic              busy,
    output logic              sc_clk_o,
    output logic              sc_rst_n_o,
    output logic              sc_in_o,
    input  logic              sc_out_i
);

    localparam int N_FRAME = N_addr + N_cnt;
    localparam int CW      = $clog2(N_FRAME + N_data + CAP_DLY) + 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] FRM_LAST  = CW'(N_FRAME - 1);
    localparam logic [CW-1:0] DAT_LAST  = CW'(N_data - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(CAP_DLY - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(N_data - 1);
    localparam logic [CW-1:0] CAP_FULL  = CW'(N_data);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_CAP,
        S_DONE
    } state_t;

    state_t               state;
    logic                 phase;
    logic [CW-1:0]        bit_cnt;
    logic [N_FRAME-1:0]   frame_sr;
    logic [N_data-1:0]    data_sr;
    // Holds the N_data-1 most recent samples; the final sample is merged straight into rdata.
    logic [N_data-2:0]    cap_sr;
    logic                 rd_op;

    assign sc_clk_o = phase;

    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            frame_sr    <= '0;
            data_sr     <= '0;
            cap_sr      <= '0;
            rd_op       <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            sc_rst_n_o  <= 1'b0;
            sc_in_o     <= 1'b0;
`ifdef SCAN_PARITY_EN
            rdata_par   <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state      <= S_RST;
                        frame_sr   <= {cmd_addr, cmd_cnt, cmd_we};
                        data_sr    <= cmd_we ? cmd_wdata : '0;
                        rd_op      <= ~cmd_we;
                        bit_cnt    <= '0;
                        phase      <= 1'b0;
                        sc_rst_n_o <= 1'b0;
                        sc_in_o    <= 1'b0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    bit_cnt   <= '0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    phase <= ~phase;
                    // phase high here means sc_clk_o is about to fall: the only edge that moves drive outputs
                    if (phase) begin
                        case (state)
                            S_RST: begin
                                if (bit_cnt == RST_LAST) begin
                                    state      <= S_ADDR;
                                    bit_cnt    <= '0;
                                    sc_rst_n_o <= 1'b1;
                                    sc_in_o    <= frame_sr[0];
                                    frame_sr   <= frame_sr >> 1;
                                end else begin
                                    bit_cnt <= bit_cnt + CW'(1);
                                end
                            end
                            S_ADDR: begin
                                if (bit_cnt == FRM_LAST) begin
                                    state   <= S_DATA;
                                    bit_cnt <= '0;
                                    sc_in_o <= data_sr[0];
                                    data_sr <= data_sr >> 1;
                                end else begin
                                    bit_cnt  <= bit_cnt + CW'(1);
                                    sc_in_o  <= frame_sr[0];
                                    frame_sr <= frame_sr >> 1;
                                end
                            end
                            S_DATA: begin
                                if (bit_cnt == DAT_LAST) begin
                                    state   <= rd_op ? S_WAIT : S_DONE;
                                    bit_cnt <= '0;
                                    sc_in_o <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + CW'(1);
                                    sc_in_o <= data_sr[0];
                                    data_sr <= data_sr >> 1;
                                end
                            end
                            S_WAIT: begin
                                if (bit_cnt == WAIT_LAST) begin
                                    state   <= S_CAP;
                                    bit_cnt <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + CW'(1);
                                end
                            end
                            S_CAP: begin
                                if (bit_cnt == CAP_FULL) begin
                                    state   <= S_DONE;
                                    bit_cnt <= '0;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end else if (state == S_CAP && bit_cnt != CAP_FULL) begin
                        cap_sr  <= {sc_out_i, cap_sr[N_data-2:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CAP_LAST) begin
                            rdata       <= {sc_out_i, cap_sr};
                            rdata_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
                            rdata_par   <= ^{sc_out_i, cap_sr};
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
